aes256_byte_collector: RTL and testbench
========================================

# aes256_byte_collector

Downstream of `aes256_loading`. Consumes its serial ciphertext byte stream (`po_next_val_ready`/`po_data`, 16 bytes per block, most-significant byte first) and reassembles complete 128-bit ciphertext blocks. Completed blocks go into a small FIFO, which the consumer drains through a valid/ready handshake. The upstream has no backpressure, so this block accepts a byte on every valid cycle and flags a block that it must drop.

## Interface
Parameters:
- `DEPTH`, default 2: FIFO depth in 128-bit blocks. Must be a power of two, ≥ 2.

Ports:
- `clk`  in  1: single clock. All flops update on its rising edge.
- `pi_rst_n`  in  1: reset, asynchronous assert, active-low.
- `pi_byte_valid`  in  1: one ciphertext byte is present this cycle. Connects to `po_next_val_ready`.
- `pi_byte`  in  8: the ciphertext byte. Connects to `po_data`.
- `pi_flush`  in  1: synchronous discard of the partially assembled block.
- `pi_out_ready`  in  1: consumer accepts the head block.
- `po_block_valid`  out  1: FIFO is non-empty.
- `po_block`  out  128: head block. Bits [127:120] are the first byte received.
- `po_byte_count`  out  4: number of bytes in the current partial block (0–15).
- `po_fifo_level`  out  $clog2(DEPTH)+1: number of blocks stored.
- `po_overflow`  out  1: sticky. Set when a completed block was dropped.

## Operation
- **Assembly register `asm` and byte index `idx` (0..15):**
  - Each cycle with `pi_byte_valid=1` and `pi_flush=0`: write `pi_byte` into `asm[127-8*idx -: 8]`, then increment `idx`.
  - When `idx==15` and a byte is accepted: the completed block is `{asm[127:8], pi_byte}`. It is pushed into the FIFO that same edge, and `idx` wraps to 0.
  - `asm` is not cleared between blocks. Every byte is overwritten before the next push.
- **Pop:** occurs when `po_block_valid && pi_out_ready`. `pi_out_ready` while the FIFO is empty has no effect.
- **Push and pop on the same edge:**
  - Always allowed, including when the FIFO is full.
  - Level is unchanged.
  - No overflow occurs.
- **Push into a full FIFO with no pop:**
  - The block is discarded.
  - FIFO contents and level are unchanged.
  - `po_overflow` is set to 1 and stays at 1 until reset.
- **Flush:**
  - `pi_flush=1` clears `idx` to 0. A byte presented in the same cycle is discarded, because flush wins.
  - Flush does not touch the FIFO or `po_overflow`. A pop in the same cycle still happens.
- **Reset (asynchronous, at any point including mid-block):**
  - `idx`, `asm`, FIFO pointers and storage are cleared.
  - Reset values: `po_block_valid=0`, `po_block=0`, `po_byte_count=0`, `po_fifo_level=0`, `po_overflow=0`.
  - A partial block in progress when reset asserts is lost. No block is emitted.
- **Value of `po_block`:**
  - Reads the head storage entry combinationally.
  - It is don't-care while `po_block_valid=0`, except directly after reset, when it reads 0.

## Timing
- **Latency:** if the 16th byte is sampled at edge N, `po_block_valid` goes high after edge N when the FIFO was empty. `po_block` is valid in that same cycle.
- **Throughput:** one byte per cycle sustained, so a block can complete every 16 cycles. Sixteen consecutive valid cycles produce exactly one block.
- **Pop timing:** a pop at edge M presents the next entry, or drops `po_block_valid`, after edge M.
- **`po_byte_count`:** equals `idx`. It updates on the same edge as the accepting byte and reads 0 right after a push.
- **Combinational paths:** none from any input to any output, except `po_block`, which follows the head pointer. There are no combinational input-to-output paths.

## Structure
- **Package `aes256_pkg`:**
  - Constants `AES_BLOCK_BITS=128` and `AES_BLOCK_BYTES=16`.
  - Typedefs `aes_block_t` (logic [127:0]) and `aes_byte_t` (logic [7:0]).
  - Shared with `aes256_loading`.
- **Sub-module `aes256_block_fifo`:**
  - Synchronous FIFO of `DEPTH` entries of `aes_block_t`, with async active-low reset.
  - Ports: push, pop, full, empty, level, head data.
  - The collector owns the overflow and push-gating logic.

## Test plan
- **Reset values:** assert `pi_rst_n=0` mid-block (after 7 bytes), then release. Required: all outputs are 0. The next 16 bytes form a clean block, with no residue from the 7 discarded bytes.
- **Single block:**
  - Stimulus: feed bytes 8e a2 b7 ca 51 67 45 bf ea fc 49 90 4b 49 60 89 (FIPS-197 AES-256 ciphertext) on consecutive cycles, with `pi_out_ready=0`.
  - Required: after the 16th edge, `po_block=128'h8ea2b7ca516745bfeafc49904b496089`, `po_block_valid=1`, `po_fifo_level=1`, `po_byte_count=0`.
- **Gapped stream:**
  - Stimulus: the same 16 bytes with random idle cycles between them.
  - Required: identical block. `po_byte_count` increments only on valid cycles.
- **Overflow:**
  - Stimulus: DEPTH=2, `pi_out_ready=0`, send 3 blocks A, B, C.
  - Required: level saturates at 2, `po_overflow=1`, and the consumer later reads A then B.
- **Full with simultaneous push/pop:**
  - Stimulus: FIFO full, `pi_out_ready=1` on the edge where the 16th byte of C arrives.
  - Required: level stays 2, `po_overflow=0`, and the read order is A, B, C.
- **Flush:**
  - Stimulus: after 5 bytes, assert `pi_flush` together with a valid byte 0xFF, then send 16 new bytes.
  - Required: `po_byte_count` reads 0 after the flush. The emitted block contains only the 16 new bytes, and 0xFF does not appear.

Source files
------------

// File: rtl/aes256_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes256_pkg
//  Description : Shared AES-256 datapath constants and types, used by the
//                loading front end and the ciphertext byte collector.
//  Revision    : 1.0 - initial release
// ============================================================================
package aes256_pkg;

    localparam int AES_BLOCK_BITS  = 128;
    localparam int AES_BLOCK_BYTES = 16;

    typedef logic [AES_BLOCK_BITS-1:0] aes_block_t;
    typedef logic [7:0]                aes_byte_t;

endpackage : aes256_pkg
`default_nettype wire

// File: rtl/aes256_block_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : aes256_block_fifo
//  Description : Synchronous FIFO of DEPTH 128-bit AES blocks. The head entry
//                is presented combinationally from the read pointer. A push
//                into a full FIFO is only honoured together with a pop.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes256_block_fifo
    import aes256_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  aes_block_t                 i_data,
    input  logic                       i_pop,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_level,
    output aes_block_t                 o_head
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_LVL_W = c_PTR_W + 1;

    aes_block_t           r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_LVL_W-1:0]   r_level;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_do_push;
    logic                 w_do_pop;
    logic [c_PTR_W-1:0]   w_wr_ptr_nxt;
    logic [c_PTR_W-1:0]   w_rd_ptr_nxt;
    logic [c_LVL_W-1:0]   w_level_nxt;

    // Qualify push/pop against occupancy and compute next pointers and level
    always_comb begin
        w_full       = (r_level == c_LVL_W'(DEPTH));
        w_empty      = (r_level == '0);
        w_do_pop     = i_pop && !w_empty;
        w_do_push    = i_push && (!w_full || w_do_pop);
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_level_nxt  = r_level;
        if (w_do_push) begin
            w_wr_ptr_nxt = r_wr_ptr + c_PTR_W'(1);
        end
        if (w_do_pop) begin
            w_rd_ptr_nxt = r_rd_ptr + c_PTR_W'(1);
        end
        if (w_do_push && !w_do_pop) begin
            w_level_nxt = r_level + c_LVL_W'(1);
        end else if (w_do_pop && !w_do_push) begin
            w_level_nxt = r_level - c_LVL_W'(1);
        end
    end

    // Pointer and level registers
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_level  <= w_level_nxt;
        end
    end

    // Block storage; cleared on reset so the head reads zero afterwards
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_level = r_level;
    assign o_head  = r_mem[r_rd_ptr];

endmodule : aes256_block_fifo
`default_nettype wire

// File: rtl/aes256_byte_collector.sv
`default_nettype none
// ============================================================================
//  Module      : aes256_byte_collector
//  Description : Reassembles the MSB-first serial ciphertext byte stream from
//                aes256_loading into 128-bit blocks and queues them in a small
//                FIFO for a valid/ready consumer. The upstream cannot be
//                stalled, so a block completing into a full FIFO (with no
//                simultaneous pop) is dropped and a sticky overflow is raised.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes256_byte_collector
    import aes256_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       pi_rst_n,
    input  logic                       pi_byte_valid,
    input  logic [7:0]                 pi_byte,
    input  logic                       pi_flush,
    input  logic                       pi_out_ready,
    output logic                       po_block_valid,
    output logic [127:0]               po_block,
    output logic [3:0]                 po_byte_count,
    output logic [$clog2(DEPTH):0]     po_fifo_level,
    output logic                       po_overflow
);

    localparam logic [3:0] c_LAST_IDX = 4'(AES_BLOCK_BYTES - 1);

    // Refuse to elaborate with an unsupported FIFO depth
    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
            $error("aes256_byte_collector: DEPTH must be a power of two >= 2");
        end
    endgenerate

    logic [3:0]                 r_idx;
    aes_block_t                 r_asm;
    logic                       r_overflow;

    logic [3:0]                 w_idx_nxt;
    aes_block_t                 w_asm_nxt;
    logic                       w_overflow_nxt;
    logic                       w_accept;
    logic                       w_block_done;
    aes_block_t                 w_completed;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_drop;

    logic                       w_fifo_full;
    logic                       w_fifo_empty;
    logic [$clog2(DEPTH):0]     w_fifo_level;
    aes_block_t                 w_fifo_head;

    // Byte acceptance, block completion, push gating and overflow detection
    always_comb begin
        w_accept       = pi_byte_valid && !pi_flush;
        w_block_done   = w_accept && (r_idx == c_LAST_IDX);
        w_completed    = {r_asm[AES_BLOCK_BITS-1:8], pi_byte};
        w_pop          = !w_fifo_empty && pi_out_ready;
        // A full FIFO still takes the block when the head leaves on this edge
        w_push         = w_block_done && (!w_fifo_full || w_pop);
        w_drop         = w_block_done && w_fifo_full && !w_pop;
        w_overflow_nxt = r_overflow || w_drop;
    end

    // Next byte index and assembly contents; flush wins over a valid byte
    always_comb begin
        w_idx_nxt = r_idx;
        w_asm_nxt = r_asm;
        if (pi_flush) begin
            w_idx_nxt = '0;
        end else if (pi_byte_valid) begin
            w_idx_nxt = r_idx + 4'd1;
            for (int i = 0; i < AES_BLOCK_BYTES; i++) begin
                if (r_idx == 4'(i)) begin
                    w_asm_nxt[AES_BLOCK_BITS-1-8*i -: 8] = pi_byte;
                end
            end
        end
    end

    // Assembly state and sticky overflow flag
    always_ff @(posedge clk or negedge pi_rst_n) begin
        if (!pi_rst_n) begin
            r_idx      <= '0;
            r_asm      <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_idx      <= w_idx_nxt;
            r_asm      <= w_asm_nxt;
            r_overflow <= w_overflow_nxt;
        end
    end

    aes256_block_fifo #(
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .i_rst_n (pi_rst_n),
        .i_push  (w_push),
        .i_data  (w_completed),
        .i_pop   (w_pop),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_level (w_fifo_level),
        .o_head  (w_fifo_head)
    );

    assign po_block_valid = !w_fifo_empty;
    assign po_block       = w_fifo_head;
    assign po_byte_count  = r_idx;
    assign po_fifo_level  = w_fifo_level;
    assign po_overflow    = r_overflow;

endmodule : aes256_byte_collector
`default_nettype wire

// File: tb/tb_aes256_byte_collector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes256_byte_collector
//  Description : Directed, table-driven self-checking bench for the AES-256
//                ciphertext byte collector (DEPTH = 2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aes256_byte_collector;

    localparam int DEPTH = 2;

    localparam logic [127:0] c_FIPS  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] c_BLK_A = 128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf;
    localparam logic [127:0] c_BLK_B = 128'hb0b1b2b3b4b5b6b7b8b9babbbcbdbebf;
    localparam logic [127:0] c_BLK_C = 128'hc0c1c2c3c4c5c6c7c8c9cacbcccdcecf;
    localparam logic [127:0] c_BLK_N = 128'h101112131415161718191a1b1c1d1e1f;

    logic         clk = 1'b0;
    logic         pi_rst_n;
    logic         pi_byte_valid;
    logic [7:0]   pi_byte;
    logic         pi_flush;
    logic         pi_out_ready;
    logic         po_block_valid;
    logic [127:0] po_block;
    logic [3:0]   po_byte_count;
    logic [1:0]   po_fifo_level;
    logic         po_overflow;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic       valid;
        logic [7:0] b;
        logic       flush;
        logic       ready;
        logic [3:0] e_cnt;
        logic       e_val;
        logic [1:0] e_lvl;
    } vec_t;

    vec_t vecs [16];

    always #5 clk = ~clk;

    aes256_byte_collector #(
        .DEPTH          (DEPTH)
    ) dut (
        .clk            (clk),
        .pi_rst_n       (pi_rst_n),
        .pi_byte_valid  (pi_byte_valid),
        .pi_byte        (pi_byte),
        .pi_flush       (pi_flush),
        .pi_out_ready   (pi_out_ready),
        .po_block_valid (po_block_valid),
        .po_block       (po_block),
        .po_byte_count  (po_byte_count),
        .po_fifo_level  (po_fifo_level),
        .po_overflow    (po_overflow)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_block(input logic [127:0] blk, input logic last_ready);
        for (int i = 0; i < 16; i++) begin
            pi_byte_valid = 1'b1;
            pi_byte       = blk[127-8*i -: 8];
            pi_out_ready  = (i == 15) ? last_ready : 1'b0;
            step();
        end
        pi_byte_valid = 1'b0;
        pi_out_ready  = 1'b0;
    endtask

    initial begin
        //            valid byte   flush ready cnt   val   lvl
        vecs[0]  = '{1'b1, 8'h8e, 1'b0, 1'b0, 4'd1,  1'b0, 2'd0};
        vecs[1]  = '{1'b1, 8'ha2, 1'b0, 1'b0, 4'd2,  1'b0, 2'd0};
        vecs[2]  = '{1'b1, 8'hb7, 1'b0, 1'b0, 4'd3,  1'b0, 2'd0};
        vecs[3]  = '{1'b1, 8'hca, 1'b0, 1'b0, 4'd4,  1'b0, 2'd0};
        vecs[4]  = '{1'b1, 8'h51, 1'b0, 1'b0, 4'd5,  1'b0, 2'd0};
        vecs[5]  = '{1'b1, 8'h67, 1'b0, 1'b0, 4'd6,  1'b0, 2'd0};
        vecs[6]  = '{1'b1, 8'h45, 1'b0, 1'b0, 4'd7,  1'b0, 2'd0};
        vecs[7]  = '{1'b1, 8'hbf, 1'b0, 1'b0, 4'd8,  1'b0, 2'd0};
        vecs[8]  = '{1'b1, 8'hea, 1'b0, 1'b0, 4'd9,  1'b0, 2'd0};
        vecs[9]  = '{1'b1, 8'hfc, 1'b0, 1'b0, 4'd10, 1'b0, 2'd0};
        vecs[10] = '{1'b1, 8'h49, 1'b0, 1'b0, 4'd11, 1'b0, 2'd0};
        vecs[11] = '{1'b1, 8'h90, 1'b0, 1'b0, 4'd12, 1'b0, 2'd0};
        vecs[12] = '{1'b1, 8'h4b, 1'b0, 1'b0, 4'd13, 1'b0, 2'd0};
        vecs[13] = '{1'b1, 8'h49, 1'b0, 1'b0, 4'd14, 1'b0, 2'd0};
        vecs[14] = '{1'b1, 8'h60, 1'b0, 1'b0, 4'd15, 1'b0, 2'd0};
        vecs[15] = '{1'b1, 8'h89, 1'b0, 1'b0, 4'd0,  1'b1, 2'd1};

        pi_rst_n      = 1'b0;
        pi_byte_valid = 1'b0;
        pi_byte       = 8'h00;
        pi_flush      = 1'b0;
        pi_out_ready  = 1'b0;
        repeat (3) step();
        pi_rst_n = 1'b1;
        step();

        chk("rst_valid", 128'(po_block_valid), 128'd0);
        chk("rst_block", po_block,             128'd0);
        chk("rst_count", 128'(po_byte_count),  128'd0);
        chk("rst_level", 128'(po_fifo_level),  128'd0);
        chk("rst_ovf",   128'(po_overflow),    128'd0);

        // Reset in the middle of a block: 7 bytes, then async reset
        for (int i = 0; i < 7; i++) begin
            pi_byte_valid = 1'b1;
            pi_byte       = 8'hff;
            step();
        end
        chk("mid_count7", 128'(po_byte_count), 128'd7);
        pi_byte_valid = 1'b0;
        pi_rst_n      = 1'b0;
        #1;
        chk("midrst_valid", 128'(po_block_valid), 128'd0);
        chk("midrst_block", po_block,             128'd0);
        chk("midrst_count", 128'(po_byte_count),  128'd0);
        chk("midrst_level", 128'(po_fifo_level),  128'd0);
        chk("midrst_ovf",   128'(po_overflow),    128'd0);
        step();
        pi_rst_n = 1'b1;
        step();

        // Single FIPS-197 block, table driven
        for (int i = 0; i < 16; i++) begin
            pi_byte_valid = vecs[i].valid;
            pi_byte       = vecs[i].b;
            pi_flush      = vecs[i].flush;
            pi_out_ready  = vecs[i].ready;
            step();
            chk($sformatf("vec%0d_count", i), 128'(po_byte_count),  128'(vecs[i].e_cnt));
            chk($sformatf("vec%0d_valid", i), 128'(po_block_valid), 128'(vecs[i].e_val));
            chk($sformatf("vec%0d_level", i), 128'(po_fifo_level),  128'(vecs[i].e_lvl));
        end
        pi_byte_valid = 1'b0;
        chk("single_block", po_block,          c_FIPS);
        chk("single_ovf",   128'(po_overflow), 128'd0);

        // Pop it
        pi_out_ready = 1'b1;
        step();
        pi_out_ready = 1'b0;
        chk("pop_valid", 128'(po_block_valid), 128'd0);
        chk("pop_level", 128'(po_fifo_level),  128'd0);

        // Gapped stream: count moves only on valid cycles
        for (int i = 0; i < 16; i++) begin
            int gaps;
            gaps = int'($urandom_range(0, 3));
            for (int g = 0; g < gaps; g++) begin
                pi_byte_valid = 1'b0;
                pi_byte       = 8'h5a;
                step();
                chk("gap_idle_count", 128'(po_byte_count), 128'(i));
            end
            pi_byte_valid = 1'b1;
            pi_byte       = c_FIPS[127-8*i -: 8];
            step();
            chk("gap_count", 128'(po_byte_count), 128'((i + 1) % 16));
        end
        pi_byte_valid = 1'b0;
        chk("gap_valid", 128'(po_block_valid), 128'd1);
        chk("gap_block", po_block,             c_FIPS);
        pi_out_ready = 1'b1;
        step();
        pi_out_ready = 1'b0;

        // Overflow: three blocks into a depth-2 FIFO with no consumer
        send_block(c_BLK_A, 1'b0);
        chk("ovf_level_a", 128'(po_fifo_level), 128'd1);
        send_block(c_BLK_B, 1'b0);
        chk("ovf_level_b", 128'(po_fifo_level), 128'd2);
        chk("ovf_flag_b",  128'(po_overflow),   128'd0);
        send_block(c_BLK_C, 1'b0);
        chk("ovf_level_c", 128'(po_fifo_level), 128'd2);
        chk("ovf_flag_c",  128'(po_overflow),   128'd1);
        chk("ovf_count_c", 128'(po_byte_count), 128'd0);
        chk("ovf_head_a",  po_block,            c_BLK_A);
        pi_out_ready = 1'b1;
        step();
        chk("ovf_head_b",  po_block,            c_BLK_B);
        chk("ovf_level_1", 128'(po_fifo_level), 128'd1);
        step();
        pi_out_ready = 1'b0;
        chk("ovf_drained", 128'(po_block_valid), 128'd0);
        chk("ovf_sticky",  128'(po_overflow),    128'd1);

        // Only reset clears the overflow flag
        pi_rst_n = 1'b0;
        #1;
        chk("ovf_cleared", 128'(po_overflow), 128'd0);
        step();
        pi_rst_n = 1'b1;
        step();

        // Full FIFO with push and pop on the same edge
        send_block(c_BLK_A, 1'b0);
        send_block(c_BLK_B, 1'b0);
        chk("fpp_level_full", 128'(po_fifo_level), 128'd2);
        chk("fpp_head_a",     po_block,            c_BLK_A);
        send_block(c_BLK_C, 1'b1);
        chk("fpp_level", 128'(po_fifo_level), 128'd2);
        chk("fpp_ovf",   128'(po_overflow),   128'd0);
        chk("fpp_head_b", po_block,           c_BLK_B);
        pi_out_ready = 1'b1;
        step();
        pi_out_ready = 1'b0;
        chk("fpp_head_c", po_block,            c_BLK_C);
        chk("fpp_level1", 128'(po_fifo_level), 128'd1);

        // Flush after 5 bytes, with a valid 0xFF and a pop on the same cycle
        for (int i = 0; i < 5; i++) begin
            pi_byte_valid = 1'b1;
            pi_byte       = 8'(i + 1);
            step();
        end
        chk("fl_count5", 128'(po_byte_count), 128'd5);
        pi_byte_valid = 1'b1;
        pi_byte       = 8'hff;
        pi_flush      = 1'b1;
        pi_out_ready  = 1'b1;
        step();
        pi_byte_valid = 1'b0;
        pi_flush      = 1'b0;
        pi_out_ready  = 1'b0;
        chk("fl_count0", 128'(po_byte_count),  128'd0);
        chk("fl_popped", 128'(po_fifo_level),  128'd0);
        chk("fl_ovf",    128'(po_overflow),    128'd0);
        send_block(c_BLK_N, 1'b0);
        chk("fl_block", po_block,             c_BLK_N);
        chk("fl_valid", 128'(po_block_valid), 128'd1);
        chk("fl_level", 128'(po_fifo_level),  128'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_aes256_byte_collector
`default_nettype wire
